// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types, state encodings and default parameters for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_W_DEF       = 5;
    localparam int unsigned FILL_CYCLES_DEF = 4;
    localparam int unsigned MEM_TIMEOUT_DEF = 8;
    localparam int unsigned CNT_W_DEF       = 16;

    typedef enum logic [1:0] {
        ST_FILL     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_e;

    // Stage control bundle driven onto the datapath each cycle.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic id_ex_bubble;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_bubble;
        logic pipe_ready;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN = '{
        pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1,
        id_ex_bubble: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0,
        mem_wb_bubble: 1'b0, pipe_ready: 1'b1};

    localparam ctrl_t CTRL_FILL = '{
        pc_write: 1'b0, if_id_write: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1,
        id_ex_bubble: 1'b0, if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1,
        mem_wb_bubble: 1'b1, pipe_ready: 1'b0};

    localparam ctrl_t CTRL_FREEZE = '{
        pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0, ex_mem_write: 1'b0,
        id_ex_bubble: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0,
        mem_wb_bubble: 1'b1, pipe_ready: 1'b1};

    localparam ctrl_t CTRL_ERROR = '{
        pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0, ex_mem_write: 1'b0,
        id_ex_bubble: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0,
        mem_wb_bubble: 1'b1, pipe_ready: 1'b0};

    // Normal-flow decode; a taken branch outranks the load-use stall since it kills ID anyway.
    function automatic ctrl_t run_decode(input logic branch, input logic hz);
        ctrl_t c;
        c = CTRL_RUN;
        if (branch) begin
            c.if_id_flush  = 1'b1;
            c.id_ex_flush  = 1'b1;
            c.ex_mem_flush = 1'b1;
        end else if (hz) begin
            c.pc_write     = 1'b0;
            c.if_id_write  = 1'b0;
            c.id_ex_bubble = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    output logic             hz
);

    assign hz = ex_memread && (ex_rd != '0)
             && ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: post-reset fill, load-use stalls, branch flushes and memory wait/timeout.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W       = REG_W_DEF,
    parameter int unsigned FILL_CYCLES = FILL_CYCLES_DEF,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_pcsrc,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_bubble,
    output logic             pipe_ready,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned FILL_W = $clog2(FILL_CYCLES + 1);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            state;
    state_e            state_nxt;
    logic [FILL_W-1:0] fill_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              err_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  flush_q;
    logic              hz;
    logic              flush_evt;
    logic              stall_evt;
    logic              timeout;
    ctrl_t             ctrl;

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .hz          (hz)
    );

    // Next-state and Mealy output decode.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        ctrl         = CTRL_RUN;
        flush_evt    = 1'b0;
        timeout      = 1'b0;
        unique case (state)
            ST_FILL: begin
                ctrl = CTRL_FILL;
                if (fill_cnt == FILL_W'(FILL_CYCLES - 1)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    ctrl         = CTRL_FREEZE;
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end else begin
                    ctrl      = run_decode(ex_mem_pcsrc, hz);
                    flush_evt = ex_mem_pcsrc;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    ctrl         = run_decode(ex_mem_pcsrc, hz);
                    flush_evt    = ex_mem_pcsrc;
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    ctrl         = CTRL_FREEZE;
                    timeout      = 1'b1;
                    state_nxt    = ST_ERROR;
                    wait_cnt_nxt = WAIT_W'(MEM_TIMEOUT);
                end else begin
                    ctrl         = CTRL_FREEZE;
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            ST_ERROR: ctrl = CTRL_ERROR;
            default:  state_nxt = ST_FILL;
        endcase
    end

    assign stall_evt = ((state == ST_RUN) || (state == ST_MEM_WAIT)) && !ctrl.pc_write;

    // State, fill/wait counters, sticky error and saturating statistics.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_FILL;
            fill_cnt <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state == ST_FILL) fill_cnt <= fill_cnt + FILL_W'(1);
            if (timeout) err_q <= 1'b1;
            if (stall_evt && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
            if (flush_evt && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign if_id_write   = ctrl.if_id_write;
    assign id_ex_write   = ctrl.id_ex_write;
    assign ex_mem_write  = ctrl.ex_mem_write;
    assign id_ex_bubble  = ctrl.id_ex_bubble;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign ex_mem_flush  = ctrl.ex_mem_flush;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;
    assign pipe_ready    = ctrl.pipe_ready;
    assign mem_error     = err_q;
    assign stall_cycles  = stall_q;
    assign flush_count   = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl, with a 4-bit-counter instance for saturation.
module tb_pipeline_hazard_ctrl;

    // Control vector order: pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble,
    // if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble, pipe_ready
    localparam logic [9:0] RUNV = 10'b1111000001;
    localparam logic [9:0] HZV  = 10'b0011100001;
    localparam logic [9:0] BRV  = 10'b1111011101;
    localparam logic [9:0] FRZ  = 10'b0000000011;
    localparam logic [9:0] ERRV = 10'b0000000010;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses;
        logic       memread;
        logic [4:0] rd;
        logic       pcsrc;
        logic       mreq;
        logic       mrdy;
        logic [9:0] exp;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs2, ex_memread, ex_mem_pcsrc, mem_req, mem_ready;

    logic        pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble, pipe_ready, mem_error;
    logic [15:0] stall_cycles, flush_count;

    logic        s_pc_write, s_if_id_write, s_id_ex_write, s_ex_mem_write, s_id_ex_bubble;
    logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_bubble, s_pipe_ready, s_mem_error;
    logic [3:0]  s_stall_cycles, s_flush_count;

    logic [9:0] ctl;
    int total = 0;
    int bad   = 0;
    int exp_stall;
    int exp_flush;
    vec_t vecs[12];

    assign ctl = {pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble,
                  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble, pipe_ready};

    always #5 clock = ~clock;

    pipeline_hazard_ctrl u_dut (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .ex_mem_pcsrc(ex_mem_pcsrc), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .mem_wb_bubble(mem_wb_bubble),
        .pipe_ready(pipe_ready), .mem_error(mem_error), .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) u_sat (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .ex_mem_pcsrc(ex_mem_pcsrc), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .id_ex_write(s_id_ex_write),
        .ex_mem_write(s_ex_mem_write), .id_ex_bubble(s_id_ex_bubble), .if_id_flush(s_if_id_flush),
        .id_ex_flush(s_id_ex_flush), .ex_mem_flush(s_ex_mem_flush), .mem_wb_bubble(s_mem_wb_bubble),
        .pipe_ready(s_pipe_ready), .mem_error(s_mem_error), .stall_cycles(s_stall_cycles),
        .flush_count(s_flush_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                         input logic mr, input logic [4:0] rd, input logic pc,
                         input logic rq, input logic rdy);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = uses; ex_memread = mr;
        ex_rd = rd; ex_mem_pcsrc = pc; mem_req = rq; mem_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Release reset just after an edge and step through the fill period.
    task automatic do_fill();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        exp_stall = 0;
        exp_flush = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, RUNV};
        vecs[1]  = '{5'd5,  5'd0,  1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, HZV};
        vecs[2]  = '{5'd0,  5'd0,  1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, RUNV};
        vecs[3]  = '{5'd1,  5'd5,  1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, RUNV};
        vecs[4]  = '{5'd1,  5'd5,  1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, HZV};
        vecs[5]  = '{5'd5,  5'd5,  1'b1, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0, RUNV};
        vecs[6]  = '{5'd5,  5'd0,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, BRV};
        vecs[7]  = '{5'd7,  5'd0,  1'b0, 1'b1, 5'd7,  1'b0, 1'b1, 1'b1, HZV};
        vecs[8]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, BRV};
        vecs[9]  = '{5'd3,  5'd4,  1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, RUNV};
        vecs[10] = '{5'd2,  5'd31, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, HZV};
        vecs[11] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 1'b1, BRV};

        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        exp_stall = 0;
        exp_flush = 0;

        // Reset held for 3 cycles.
        for (int i = 0; i < 3; i++) tick();
        chk("rst_pipe_ready", 32'(pipe_ready), 32'd0);
        chk("rst_mem_error", 32'(mem_error), 32'd0);
        chk("rst_stall", 32'(stall_cycles), 32'd0);
        chk("rst_flush", 32'(flush_count), 32'd0);

        // Fill: four cycles of forced flush; a hazard in fill is ignored.
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
            else drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            #1;
            chk("fill_pc_write", 32'(pc_write), 32'd0);
            chk("fill_if_id_write", 32'(if_id_write), 32'd1);
            chk("fill_flushes", 32'({if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble}), 32'hF);
            chk("fill_pipe_ready", 32'(pipe_ready), 32'd0);
            tick();
        end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("fill_done_ctl", 32'(ctl), 32'(RUNV));
        chk("fill_no_stall_count", 32'(stall_cycles), 32'd0);

        // Single-cycle RUN decode table.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].uses, vecs[i].memread,
                  vecs[i].rd, vecs[i].pcsrc, vecs[i].mreq, vecs[i].mrdy);
            #1;
            chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].exp));
            tick();
            if (!vecs[i].exp[9]) exp_stall++;
            if (vecs[i].pcsrc) exp_flush++;
            chk($sformatf("vec%0d_stall", i), 32'(stall_cycles), 32'(exp_stall));
            chk($sformatf("vec%0d_flush", i), 32'(flush_count), 32'(exp_flush));
        end

        // Memory wait with a branch pending: frozen for 3 cycles, flush only on release.
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
            #1;
            chk($sformatf("mwait%0d_ctl", i), 32'(ctl), 32'(FRZ));
            tick();
        end
        exp_stall += 3;
        chk("mwait_stall", 32'(stall_cycles), 32'(exp_stall));
        chk("mwait_flush_held", 32'(flush_count), 32'(exp_flush));
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("mwait_release_ctl", 32'(ctl), 32'(BRV));
        tick();
        exp_flush++;
        chk("mwait_release_flush", 32'(flush_count), 32'(exp_flush));
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("mwait_back_run", 32'(ctl), 32'(RUNV));

        // Asynchronous reset mid-RUN.
        #2 reset = 1'b0;
        #1;
        chk("async_rst_ready", 32'(pipe_ready), 32'd0);
        chk("async_rst_flush", 32'(flush_count), 32'd0);
        tick();
        do_fill();

        // Timeout: 8 frozen cycles, then ERROR.
        for (int i = 0; i < 8; i++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            #1;
            chk($sformatf("tmo%0d_ctl", i), 32'(ctl), 32'(FRZ));
            chk($sformatf("tmo%0d_err", i), 32'(mem_error), 32'd0);
            tick();
        end
        chk("err_ctl", 32'(ctl), 32'(ERRV));
        chk("err_flag", 32'(mem_error), 32'd1);
        chk("err_stall", 32'(stall_cycles), 32'd8);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        chk("err_stuck_ctl", 32'(ctl), 32'(ERRV));
        chk("err_stuck_flag", 32'(mem_error), 32'd1);
        chk("err_no_count", 32'(stall_cycles), 32'd8);
        chk("err_no_flush", 32'(flush_count), 32'd0);
        reset = 1'b0;
        #1;
        chk("err_rst_clear", 32'(mem_error), 32'd0);
        chk("err_rst_stall", 32'(stall_cycles), 32'd0);
        tick();
        do_fill();

        // Saturation: 20 continuous load-use stalls.
        drive(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 15) chk("sat_at_15", 32'(s_stall_cycles), 32'd15);
        end
        chk("sat_ctl", 32'({s_pc_write, s_if_id_write, s_id_ex_bubble}), 32'b001);
        chk("sat_held", 32'(s_stall_cycles), 32'd15);
        chk("nosat_wide", 32'(stall_cycles), 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
- Generates the write-enable, bubble and flush controls for the PC and each pipeline register.
- Sources of those controls: post-reset fill, load-use hazards, taken branches (EX/MEM PCSrc) and a data-memory ready handshake with timeout.
- Sits beside the datapath in the top-level; consumes decoded register fields and control bits, and drives stage enables.

Parameters:
- REG_W, 5, register-address width.
- FILL_CYCLES, 4, cycles of forced flush after reset release.
- MEM_TIMEOUT, 8, maximum consecutive data-memory wait cycles before error.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1  in  REG_W  rs1 of the instruction in ID.
- id_rs2  in  REG_W  rs2 of the instruction in ID.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_memread  in  1  instruction in EX is a load.
- ex_rd  in  REG_W  destination register of the EX instruction.
- ex_mem_pcsrc  in  1  taken branch resolved at EX/MEM.
- mem_req  in  1  MEM stage issues a data-memory read or write.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC register update enable.
- if_id_write  out  1  IF/ID register write enable.
- id_ex_write  out  1  ID/EX register write enable.
- ex_mem_write  out  1  EX/MEM register write enable.
- id_ex_bubble  out  1  zero the control fields entering ID/EX.
- if_id_flush  out  1  clear IF/ID.
- id_ex_flush  out  1  clear ID/EX.
- ex_mem_flush  out  1  clear EX/MEM control fields.
- mem_wb_bubble  out  1  zero regwrite entering MEM/WB.
- pipe_ready  out  1  controller is in RUN or MEM_WAIT.
- mem_error  out  1  sticky memory-timeout flag.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0 in RUN or MEM_WAIT.
- flush_count  out  CNT_W  saturating count of branch flushes.

Behaviour:
- States: FILL, RUN, MEM_WAIT, ERROR. The state register and all counters are async-cleared by reset=0.
- Values while reset=0: state=FILL, fill counter=0, wait counter=0, mem_error=0, stall_cycles=0, flush_count=0.
- Output decode is combinational from state and current inputs (Mealy).
- Load-use hazard: hz = ex_memread & (ex_rd!=0) & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
- FILL:
  - Outputs: pc_write=0, all *_write=1, all flushes=1, mem_wb_bubble=1, pipe_ready=0.
  - Stays for exactly FILL_CYCLES clock edges after reset deasserts, then moves to RUN.
  - A load-use hazard is not evaluated in FILL.
- RUN, in priority order:
  - (1) mem_req & !mem_ready: freeze.
    - pc_write, if_id_write, id_ex_write and ex_mem_write all 0; mem_wb_bubble=1.
    - Next state MEM_WAIT; wait counter=1.
  - (2) ex_mem_pcsrc: if_id_flush=id_ex_flush=ex_mem_flush=1, pc_write=1, flush_count+1.
  - (3) hz: pc_write=0, if_id_write=0, id_ex_bubble=1. This is a single-cycle stall and is re-evaluated every cycle.
  - Otherwise: all writes=1, all flushes and bubbles=0.
  - A branch has priority over hz in the same cycle: the flush kills the hazarding ID instruction.
- MEM_WAIT:
  - Freeze outputs are held (as in RUN case 1); the wait counter increments each cycle.
  - mem_ready=1: that cycle behaves as RUN decode with the freeze cause removed, and the next state is RUN.
    - A branch pending in EX/MEM is therefore flushed on the release cycle, not earlier.
  - If the wait counter reaches MEM_TIMEOUT with mem_ready=0: mem_error=1, next state ERROR.
- ERROR:
  - All write enables are 0, all flushes are 0, mem_wb_bubble=1, pipe_ready=0.
  - Only reset exits this state; mem_error stays 1 until reset.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-operation returns to FILL immediately and asynchronously.

Decomposition:
- Shared defines include file holds:
  - state encodings: FILL=2'd0, RUN=2'd1, MEM_WAIT=2'd2, ERROR=2'd3;
  - default parameter values.
- One combinational sub-module, hazard_detect, computes hz from id_rs1, id_rs2, id_uses_rs2, ex_memread and ex_rd.
- The FSM, output decode and counters live in pipeline_hazard_ctrl.

Test Plan:
1. Fill: reset=0 for 3 cycles, then 1.
   - 4 cycles: pc_write=0, all flushes=1.
   - 5th cycle: pipe_ready=1, pc_write=1.
   - Also: reset=0 mid-RUN drops pipe_ready asynchronously.
2. Load-use: ex_memread=1, ex_rd=5, id_rs1=5 → same cycle pc_write=0, if_id_write=0, id_ex_bubble=1.
   - Repeat with ex_rd=0, and with id_rs2=5 and id_uses_rs2=0 → no stall.
3. Branch: ex_mem_pcsrc=1 for 1 cycle, with hz=1 in the same cycle.
   - if_id_flush, id_ex_flush and ex_mem_flush all =1; pc_write=1; id_ex_bubble=0; flush_count 0→1.
4. Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1, with ex_mem_pcsrc=1 throughout.
   - Freeze for 3 cycles; stall_cycles +3; flushes appear only on the release cycle.
5. Timeout: mem_ready held 0 with MEM_TIMEOUT=8.
   - mem_error=1 on the 8th wait cycle; ERROR holds all writes=0.
   - A later mem_ready=1 does not exit ERROR; reset=0 clears mem_error.
6. Saturation: CNT_W=4, continuous load-use stalls for 20 cycles → stall_cycles stops at 15 and does not wrap.
